sort_stream_host: RTL and testbench

SORT_STREAM_HOST -- requirements
Module: sort_stream_host

---
 rtl/sort_pkg.sv | 16 +
 rtl/sort_host_cnt.sv | 25 ++
 rtl/sort_stream_host.sv | 128 ++++++++++++
 tb/tb_sort_stream_host.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// sort_pkg: shared FSM encoding and default sizes for the sort stream host.
package sort_pkg;

    localparam int SORT_N = 8;
    localparam int SORT_L = 4;

    typedef enum logic [2:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_RDREQ,
        S_RDCAP,
        S_OUT
    } state_t;

endpackage

// File: rtl/sort_host_cnt.sv
// sort_host_cnt: L-bit enabled wrapping counter with clear and terminal-count flag.
module sort_host_cnt #(
    parameter int L = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [L-1:0] q,
    output logic         tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + L'(1);
        end
    end

    assign tc = &q;

endmodule

// File: rtl/sort_stream_host.sv
// sort_stream_host: streams a D-word block into an external sorter and drains it.
// Define SORT_HOST_DESCEND_EN to read the sorted block back largest-first.
module sort_stream_host
    import sort_pkg::*;
#(
    parameter int N = SORT_N,
    parameter int L = SORT_L
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] m_data,
    output logic         m_last,
    output logic         srt_wrinit,
    output logic         srt_rd,
    output logic         srt_start,
    output logic [L-1:0] srt_addr,
    output logic [N-1:0] srt_datain,
    input  logic [N-1:0] srt_dataout,
    input  logic         srt_done,
    output logic         busy
);

    localparam logic [L-1:0] LAST_ADDR = '1;

    state_t state, state_nx;

    logic [L-1:0] ld_cnt, rd_cnt, rd_addr;
    logic         ld_tc, rd_tc;
    logic         s_hs, m_hs;
    logic         wr_q, start_q;
    logic [L-1:0] waddr_q;
    logic [N-1:0] wdata_q;

    assign s_hs = s_valid & s_ready;
    assign m_hs = m_valid & m_ready;

    sort_host_cnt #(.L(L)) u_ld_cnt (
        .clk (clk),
        .rst (rst),
        .en  (s_hs),
        .clr (1'b0),
        .q   (ld_cnt),
        .tc  (ld_tc)
    );

    sort_host_cnt #(.L(L)) u_rd_cnt (
        .clk (clk),
        .rst (rst),
        .en  (m_hs),
        .clr (state == S_WAIT),
        .q   (rd_cnt),
        .tc  (rd_tc)
    );

`ifdef SORT_HOST_DESCEND_EN
    assign rd_addr = LAST_ADDR - rd_cnt;
`else
    assign rd_addr = rd_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // start_q is high only in the first WAIT cycle, which doubles as the
    // marker for ignoring a done flag left over from the previous block.
    always_comb begin
        state_nx = state;
        s_ready  = 1'b0;
        srt_rd   = 1'b0;
        m_valid  = 1'b0;
        unique case (state)
            S_LOAD: begin
                s_ready = 1'b1;
                if (s_hs && ld_tc) state_nx = S_START;
            end
            S_START: state_nx = S_WAIT;
            S_WAIT: begin
                if (srt_done && !start_q) state_nx = S_RDREQ;
            end
            S_RDREQ: begin
                srt_rd   = 1'b1;
                state_nx = S_RDCAP;
            end
            S_RDCAP: state_nx = S_OUT;
            S_OUT: begin
                m_valid = 1'b1;
                if (m_ready) state_nx = rd_tc ? S_LOAD : S_RDREQ;
            end
            default: state_nx = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            start_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            m_data  <= '0;
        end else begin
            wr_q    <= s_hs;
            start_q <= (state == S_START);
            if (s_hs) begin
                waddr_q <= ld_cnt;
                wdata_q <= s_data;
            end
            if (state == S_RDCAP) m_data <= srt_dataout;
        end
    end

    assign srt_wrinit = wr_q;
    assign srt_start  = start_q;
    assign srt_datain = wdata_q;
    assign srt_addr   = srt_rd ? rd_addr : waddr_q;
    assign m_last     = m_valid & rd_tc;
    assign busy       = (state != S_LOAD) || (ld_cnt != '0);

endmodule

// File: tb/tb_sort_stream_host.sv
// tb_sort_stream_host: table-driven and random block checks with a sorter model.
module tb_sort_stream_host;

    localparam int N = 8;
    localparam int L = 4;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid, s_ready;
    logic [N-1:0] s_data;
    logic         m_valid, m_ready, m_last;
    logic [N-1:0] m_data;
    logic         srt_wrinit, srt_rd, srt_start;
    logic [L-1:0] srt_addr;
    logic [N-1:0] srt_datain;
    logic [N-1:0] srt_dataout;
    logic         srt_done;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sort_stream_host #(.N(N), .L(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .srt_wrinit  (srt_wrinit),
        .srt_rd      (srt_rd),
        .srt_start   (srt_start),
        .srt_addr    (srt_addr),
        .srt_datain  (srt_datain),
        .srt_dataout (srt_dataout),
        .srt_done    (srt_done),
        .busy        (busy)
    );

    // External sorter: memory with 1-cycle read, sorts in place after start.
    logic [N-1:0] mem [D];
    logic         stale_mode = 1'b0;
    int           sort_cnt = 0;

    task automatic sort_mem();
        logic [N-1:0] q[$];
        for (int i = 0; i < D; i++) q.push_back(mem[i]);
        q.sort();
        for (int i = 0; i < D; i++) mem[i] = q[i];
    endtask

    initial begin
        srt_done = 1'b0;
        srt_dataout = '0;
    end

    always @(posedge clk) begin
        if (srt_rd) srt_dataout <= mem[srt_addr];
        if (srt_wrinit) mem[srt_addr] = srt_datain;
        if (srt_start) begin
            if (stale_mode) begin
                sort_mem();
                srt_done <= 1'b1;
                sort_cnt = 0;
            end else begin
                srt_done <= 1'b0;
                sort_cnt = 4;
            end
        end else if (sort_cnt > 0) begin
            sort_cnt--;
            if (sort_cnt == 0) begin
                sort_mem();
                srt_done <= 1'b1;
            end
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("strobe_excl", 32'(srt_wrinit) + 32'(srt_rd) + 32'(srt_start) <= 1, 1);
        end
    end

    typedef struct {
        logic [N-1:0] din [D];
        logic [N-1:0] asc [D];
        int           mode;
    } vec_t;

    vec_t tbl [3];

    task automatic load_block(input logic [N-1:0] w [D], input int cnt);
        int k = 0;
        int guard = 0;
        while (k < cnt && guard < 200) begin
            @(posedge clk); #1;
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = w[k];
            @(negedge clk);
            if (s_valid && s_ready) k++;
            guard++;
        end
        if (k < cnt) chk("load_timeout", k, cnt);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic drain_block(input logic [N-1:0] exp [D], input bit stall);
        int k = 0;
        int guard = 0;
        bit stalled = 0;
        logic [N-1:0] held;
        while (k < D && guard < 600) begin
            @(posedge clk); #1;
            m_ready = ($urandom_range(0, 3) != 0);
            s_valid = 1'($urandom_range(0, 1));
            s_data  = N'($urandom);
            @(negedge clk);
            guard++;
            chk("s_ready_busy", s_ready, 0);
            chk("wrinit_busy", srt_wrinit, 0);
            if (stall && !stalled && k == 5 && m_valid) begin
                stalled = 1;
                m_ready = 1'b0;
                held = m_data;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_valid", m_valid, 1);
                    chk("stall_data", m_data, held);
                    chk("stall_no_rd", srt_rd, 0);
                end
            end else if (m_valid && m_ready) begin
                chk($sformatf("data[%0d]", k), m_data, exp[k]);
                chk($sformatf("last[%0d]", k), m_last, (k == D - 1));
                k++;
            end
        end
        if (k < D) chk("drain_timeout", k, D);
        @(posedge clk); #1;
        m_ready = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic run_block(input logic [N-1:0] din [D],
                             input logic [N-1:0] asc [D], input int mode);
        logic [N-1:0] exp [D];
        int g;
        for (int i = 0; i < D; i++) begin
`ifdef SORT_HOST_DESCEND_EN
            exp[i] = asc[D - 1 - i];
`else
            exp[i] = asc[i];
`endif
        end
        stale_mode = (mode == 2);
        load_block(din, D);
        if (mode == 2) begin
            g = 0;
            do begin
                @(negedge clk);
                g++;
            end while (!srt_start && g < 10);
            chk("start_seen", srt_start, 1);
            chk("stale_done", srt_done, 1);
            @(negedge clk);
            chk("no_rd_first_wait", srt_rd, 0);
            @(negedge clk);
            chk("rd_after_wait", srt_rd, 1);
        end
        drain_block(exp, mode == 1);
        stale_mode = 1'b0;
        @(negedge clk);
        chk("idle_after_block", busy, 0);
    endtask

    initial begin
        logic [N-1:0] rin [D];
        logic [N-1:0] rsrt [D];
        logic [N-1:0] q[$];

        tbl[0].din  = '{8'd9, 8'd3, 8'd15, 8'd0, 8'd12, 8'd7, 8'd1, 8'd14,
                        8'd5, 8'd10, 8'd2, 8'd13, 8'd8, 8'd4, 8'd11, 8'd6};
        tbl[0].asc  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
                        8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
        tbl[0].mode = 1;
        tbl[1].din  = tbl[0].asc;
        tbl[1].asc  = tbl[0].asc;
        tbl[1].mode = 2;
        tbl[2].din  = '{8'd7, 8'd7, 8'd255, 8'd0, 8'd128, 8'd1, 8'd7, 8'd64,
                        8'd3, 8'd3, 8'd200, 8'd9, 8'd0, 8'd100, 8'd50, 8'd2};
        tbl[2].asc  = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd7, 8'd7,
                        8'd7, 8'd9, 8'd50, 8'd64, 8'd100, 8'd128, 8'd200, 8'd255};
        tbl[2].mode = 0;

        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_strobes", {srt_wrinit, srt_rd, srt_start, m_last}, 0);
        chk("rst_m_data", m_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int t = 0; t < 3; t++) begin
            run_block(tbl[t].din, tbl[t].asc, tbl[t].mode);
        end

        load_block(tbl[2].din, 7);
        chk("mid_load_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_s_ready", s_ready, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_wrinit", srt_wrinit, 0);
        chk("rst_mid_m_valid", m_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_block(tbl[0].din, tbl[0].asc, 0);

        for (int r = 0; r < 3; r++) begin
            q.delete();
            for (int i = 0; i < D; i++) begin
                rin[i] = N'($urandom);
                q.push_back(rin[i]);
            end
            q.sort();
            for (int i = 0; i < D; i++) rsrt[i] = q[i];
            run_block(rin, rsrt, r % 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
